gpr_file: RTL and testbench

General-purpose register file for the single-cycle RV64 core, instantiated inside the instruction-decode stage. It holds NR_REG architectural integer registers, x0 hardwired to zero. A key-matched one-hot decoder selects the destination register. Two asynchronous read ports supply operands, and one synchronous write port takes the execute result.

---
 rtl/gpr_file.sv | 79 +++++++
 tb/tb_gpr_file.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/gpr_file.sv
// Integer register file for the RV64 decode stage: NR_REG x XLEN registers,
// x0 tied to zero, two combinational read ports, one synchronous write port.
module gpr_file #(
    parameter int              XLEN      = 64,
    parameter int              NR_REG    = 32,
    parameter int              REG_SEL   = 5,
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wen,
    input  logic [REG_SEL-1:0]     waddr,
    input  logic [XLEN-1:0]        wdata,
    input  logic [REG_SEL-1:0]     raddr1,
    input  logic [REG_SEL-1:0]     raddr2,
    output logic [XLEN-1:0]        rdata1,
    output logic [XLEN-1:0]        rdata2,
    output logic [NR_REG-1:0]      wen_vec,
    output logic [XLEN*NR_REG-1:0] gpr_flat
);

    logic [NR_REG-1:0] dest_onehot;
    logic [XLEN-1:0]   gpr_q [NR_REG];
    logic [XLEN-1:0]   gpr_d [NR_REG];

    // Key/value destination lookup: keys 1..NR_REG-1 map to their own bit;
    // key 0 and anything unmatched fall through to the all-zero default.
    always_comb begin
        // NOTE: assigning the default before any conditional update keeps
        // every path driven, so no latch can be inferred here.
        dest_onehot = '0;
        for (int k = 1; k < NR_REG; k++) begin
            if (waddr == REG_SEL'(k)) begin
                dest_onehot = NR_REG'(1) << k;
            end
        end
    end

    assign wen_vec = wen ? dest_onehot : '0;

    always_comb begin
        for (int i = 0; i < NR_REG; i++) begin
            gpr_d[i] = wen_vec[i] ? wdata : gpr_q[i];
        end
        // x0 is architecturally zero; its strobe can never fire anyway.
        gpr_d[0] = RESET_VAL;
    end

    // NOTE: this storage is built from flops rather than an SRAM macro, so the
    // whole array can and must be cleared by reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge state, independent of statement order.
        if (rst) begin
            for (int i = 0; i < NR_REG; i++) begin
                gpr_q[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NR_REG; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
        end
    end

    // Reads see the pre-edge state: no write-to-read bypass.
    assign rdata1 = gpr_q[raddr1];
    assign rdata2 = gpr_q[raddr2];

    always_comb begin
        gpr_flat = '0;
        for (int i = 0; i < NR_REG; i++) begin
            gpr_flat[i*XLEN +: XLEN] = gpr_q[i];
        end
    end

    wen_vec_onehot_a : assert property (@(posedge clk) $onehot0(wen_vec));
    x0_never_strobed_a : assert property (@(posedge clk) wen_vec[0] == 1'b0);

endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: an array model of the architectural registers
// is checked against every output on each negative clock edge.
module tb_gpr_file;

    localparam int XLEN   = 64;
    localparam int NR_REG = 32;
    localparam int SEL    = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   wen;
    logic [SEL-1:0]         waddr;
    logic [XLEN-1:0]        wdata;
    logic [SEL-1:0]         raddr1;
    logic [SEL-1:0]         raddr2;
    logic [XLEN-1:0]        rdata1;
    logic [XLEN-1:0]        rdata2;
    logic [NR_REG-1:0]      wen_vec;
    logic [XLEN*NR_REG-1:0] gpr_flat;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [XLEN-1:0] model [NR_REG];

    gpr_file #(
        .XLEN     (XLEN),
        .NR_REG   (NR_REG),
        .REG_SEL  (SEL),
        .RESET_VAL('0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr1  (raddr1),
        .raddr2  (raddr2),
        .rdata1  (rdata1),
        .rdata2  (rdata2),
        .wen_vec (wen_vec),
        .gpr_flat(gpr_flat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: reset clears everything, an enabled write to a
    // nonzero index updates that register, everything else holds.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_REG; i++) model[i] <= '0;
        end else if (wen && waddr != 0) begin
            model[waddr] <= wdata;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("rdata1", rdata1, model[raddr1]);
            check("rdata2", rdata2, model[raddr2]);
            check("wen_vec", 64'(wen_vec), (wen && waddr != 0) ? (64'(1) << waddr) : 64'(0));
            for (int i = 0; i < NR_REG; i++) begin
                check($sformatf("gpr_flat[%0d]", i), gpr_flat[i*XLEN +: XLEN], model[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a simultaneous write request that must be dropped.
        rst = 1'b1; wen = 1'b1; waddr = 5'd5; wdata = 64'hDEAD;
        raddr1 = 5'd5; raddr2 = 5'd0;
        #2;
        check("wen_vec during reset", 64'(wen_vec), 64'h20);
        step();
        rst = 1'b0; wen = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("x5 after reset", rdata1, 64'h0);
        check("x0 after reset", rdata2, 64'h0);
        for (int i = 0; i < NR_REG; i++) begin
            check($sformatf("reset slice %0d", i), gpr_flat[i*XLEN +: XLEN], 64'h0);
        end

        // Basic write; the read of the same register sees the old value first.
        wen = 1'b1; waddr = 5'd10; wdata = 64'h0123_4567_89AB_CDEF; raddr1 = 5'd10;
        #2;
        check("x10 before edge", rdata1, 64'h0);
        check("wen_vec x10", 64'(wen_vec), 64'h0000_0400);
        step();
        wen = 1'b0;
        #1;
        check("x10 after edge", rdata1, 64'h0123_4567_89AB_CDEF);

        wen = 1'b1; waddr = 5'd31; wdata = 64'h1234;
        step();

        // x0 write attempt.
        wen = 1'b1; waddr = 5'd0; wdata = '1; raddr1 = 5'd0;
        #2;
        check("wen_vec x0", 64'(wen_vec), 64'h0);
        step();
        wen = 1'b0;
        #1;
        check("x0 after write", rdata1, 64'h0);

        // Write disabled.
        wen = 1'b0; waddr = 5'd31; wdata = 64'h55; raddr1 = 5'd31;
        #2;
        check("wen_vec disabled", 64'(wen_vec), 64'h0);
        step();
        #1;
        check("x31 held", rdata1, 64'h1234);

        // Sweep writes to x1..x31, reading the target during its write cycle.
        for (int i = 1; i < NR_REG; i++) begin
            wen = 1'b1; waddr = SEL'(i); wdata = 64'(i) * 64'h1111;
            raddr1 = SEL'(i); raddr2 = SEL'(i - 1);
            step();
        end
        wen = 1'b0;
        for (int i = 1; i < NR_REG; i++) begin
            raddr1 = SEL'(i); raddr2 = SEL'(32 - i);
            #2;
            check($sformatf("sweep rd1 x%0d", i), rdata1, 64'(i) * 64'h1111);
            check($sformatf("sweep rd2 x%0d", 32 - i), rdata2, 64'(32 - i) * 64'h1111);
            check($sformatf("sweep slice %0d", i), gpr_flat[i*XLEN +: XLEN], 64'(i) * 64'h1111);
            step();
        end
        raddr1 = 5'd0; raddr2 = 5'd0;
        #2;
        check("sweep x0 rd1", rdata1, 64'h0);
        check("sweep x0 rd2", rdata2, 64'h0);
        step();

        // Mid-run reset, again with a write request that must be dropped.
        rst = 1'b1; wen = 1'b1; waddr = 5'd7; wdata = 64'hBEEF; raddr1 = 5'd7; raddr2 = 5'd20;
        step();
        rst = 1'b0; wen = 1'b0;
        #1;
        check("x7 after mid reset", rdata1, 64'h0);
        check("x20 after mid reset", rdata2, 64'h0);
        for (int i = 0; i < NR_REG; i++) begin
            check($sformatf("mid reset slice %0d", i), gpr_flat[i*XLEN +: XLEN], 64'h0);
        end
        wen = 1'b1; waddr = 5'd3; wdata = 64'd7; raddr1 = 5'd3; raddr2 = 5'd3;
        step();
        wen = 1'b0;
        #1;
        check("x3 rd1 after reset", rdata1, 64'd7);
        check("x3 rd2 after reset", rdata2, 64'd7);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
